// File: rtl/fp32_mac.sv
// Single-lane binary32 multiply-accumulate: acc <= acc + x*w, one MAC per 3-clock window.
// Round-to-nearest-even, subnormals flushed to zero, canonical quiet NaN.
module fp32_mac (
  input  logic        clk_x70,
  input  logic        reset_x70,
  input  logic [31:0] x_x70,
  input  logic [31:0] w_x70,
  output logic [31:0] y_x70
);

  typedef enum logic [1:0] {PhLoad, PhMul, PhAcc} phase_e;

  localparam logic [31:0] QNan = 32'h7FC0_0000;

  phase_e      phase_q;
  logic [31:0] x_q, w_q, prod_q, acc_q;

  // m carries the hidden bit; e is the biased exponent belonging to m.
  function automatic logic [31:0] pack_rne(input logic s, input logic signed [10:0] e,
                                           input logic [23:0] m, input logic g,
                                           input logic st);
    logic [24:0]        mr;
    logic [22:0]        frac;
    logic signed [10:0] er;
    mr   = {1'b0, m} + {24'd0, g & (st | m[0])};
    er   = mr[24] ? e + 11'sd1 : e;
    frac = mr[24] ? mr[23:1] : mr[22:0];
    if (er >= 11'sd255) return {s, 8'hFF, 23'd0};
    if (er <= 11'sd0) return {s, 31'd0};
    return {s, er[7:0], frac};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0]        p;
    logic signed [10:0] e;
    s      = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return QNan;
    if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    if (p[47]) return pack_rne(s, e + 11'sd1, p[47:24], p[23], |p[22:0]);
    return pack_rne(s, e, p[46:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sl, ss;
    logic [7:0]         el, es, d;
    logic [26:0]        ml, ms, sh, n;
    logic [27:0]        sum;
    logic [4:0]         lz;
    logic signed [10:0] e;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    if (a_nan || b_nan) return QNan;
    if (a_inf && b_inf) return (a[31] != b[31]) ? QNan : a;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a_zero && b_zero) return {a[31] & b[31], 31'd0};
    if (b_zero) return a;
    if (a_zero) return b;
    // Order by magnitude so the subtraction never goes negative.
    if (b[30:0] > a[30:0]) begin
      sl = b[31]; el = b[30:23]; ml = {1'b1, b[22:0], 3'b000};
      ss = a[31]; es = a[30:23]; ms = {1'b1, a[22:0], 3'b000};
    end else begin
      sl = a[31]; el = a[30:23]; ml = {1'b1, a[22:0], 3'b000};
      ss = b[31]; es = b[30:23]; ms = {1'b1, b[22:0], 3'b000};
    end
    d = el - es;
    if (d >= 8'd27) sh = 27'd1;
    else sh = (ms >> d) | {26'd0, |(ms & ((27'd1 << d) - 27'd1))};
    sum = (sl ^ ss) ? {1'b0, ml} - {1'b0, sh} : {1'b0, ml} + {1'b0, sh};
    if (sum == 28'd0) return 32'd0;
    e = $signed({3'b000, el});
    if (sum[27]) begin
      n = {sum[27:2], sum[1] | sum[0]};
      e = e + 11'sd1;
    end else begin
      lz = 5'd0;
      for (int i = 0; i <= 26; i++) if (sum[i]) lz = 5'(26 - i);
      n = sum[26:0] << lz;
      e = e - $signed({6'd0, lz});
    end
    return pack_rne(sl, e, n[26:3], n[2], n[1] | n[0]);
  endfunction

  always_ff @(posedge clk_x70) begin
    if (reset_x70) begin
      phase_q <= PhLoad;
      x_q     <= 32'd0;
      w_q     <= 32'd0;
      prod_q  <= 32'd0;
      acc_q   <= 32'd0;
    end else begin
      unique case (phase_q)
        PhLoad: begin
          x_q     <= x_x70;
          w_q     <= w_x70;
          phase_q <= PhMul;
        end
        PhMul: begin
          prod_q  <= fp_mul(x_q, w_q);
          phase_q <= PhAcc;
        end
        PhAcc: begin
          acc_q   <= fp_add(acc_q, prod_q);
          phase_q <= PhLoad;
        end
        default: phase_q <= PhLoad;
      endcase
    end
  end

  assign y_x70 = acc_q;

endmodule

// File: tb/tb_fp32_mac.sv
// Self-checking bench for fp32_mac: directed vector table, reset-abort sequence and
// randomized windows against a real-arithmetic reference model.
module tb_fp32_mac;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] x = 32'd0, w = 32'd0, y;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  fp32_mac dut (
    .clk_x70  (clk),
    .reset_x70(reset),
    .x_x70    (x),
    .w_x70    (w),
    .y_x70    (y)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // ---------------- reference model (value-level, via double precision) ----------------
  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction
  function automatic logic is_inf(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
  endfunction
  function automatic logic is_zero(input logic [31:0] f);
    return f[30:23] == 8'h00;
  endfunction

  function automatic real to_real(input logic [31:0] f);
    logic [10:0] de;
    if (is_zero(f)) return 0.0;
    de = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], de, f[22:0], 29'd0});
  endfunction

  // Round an exact double to binary32, RNE, flush-to-zero, overflow to Inf.
  function automatic logic [31:0] round32(input real r);
    logic [63:0] d;
    logic [24:0] mr;
    int          e;
    d  = $realtobits(r);
    e  = int'(d[62:52]) - 1023 + 127;
    mr = {2'b01, d[51:29]} + 25'(d[28] && ((|d[27:0]) || d[29]));
    if (mr[24]) begin
      mr = mr >> 1;
      e++;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0) return {d[63], 31'd0};
    return {d[63], e[7:0], mr[22:0]};
  endfunction

  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    logic s = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b)) return QNAN;
    if ((is_inf(a) && is_zero(b)) || (is_inf(b) && is_zero(a))) return QNAN;
    if (is_inf(a) || is_inf(b)) return {s, 8'hFF, 23'd0};
    if (is_zero(a) || is_zero(b)) return {s, 31'd0};
    return round32(to_real(a) * to_real(b));
  endfunction

  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    real r;
    if (is_nan(a) || is_nan(b)) return QNAN;
    if (is_inf(a) && is_inf(b) && a[31] != b[31]) return QNAN;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    if (is_zero(a) && is_zero(b)) return {a[31] & b[31], 31'd0};
    if (is_zero(b)) return a;
    if (is_zero(a)) return b;
    r = to_real(a) + to_real(b);
    if (r == 0.0) return 32'd0;
    return round32(r);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_y", y, 32'd0);
  endtask

  // Releases reset (if held) at the negedge before the phase-0 edge.
  task automatic run_window(input logic [31:0] xv, input logic [31:0] wv,
                            output logic [31:0] y_mid, output logic [31:0] y_end);
    @(negedge clk);
    reset = 1'b0;
    x = xv;
    w = wv;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 y_mid = y;
    @(posedge clk);
    #1 y_end = y;
  endtask

  function automatic logic [31:0] rand_operand();
    logic [7:0] e;
    if ($urandom_range(0, 15) == 0) return {1'($urandom), 31'd0};
    e = 8'(123 + $urandom_range(0, 8));
    return {1'($urandom), e, 8'($urandom), 15'd0};
  endfunction

  typedef struct {
    logic        rst;
    logic [31:0] xv;
    logic [31:0] wv;
    logic [31:0] exp_y;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] ym, ye, prev, acc, xr, wr;

    vecs.push_back('{1'b1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000});
    vecs.push_back('{1'b0, 32'h3F00_0000, 32'h3F00_0000, 32'h40C8_0000});
    vecs.push_back('{1'b0, 32'hBFC0_0000, 32'h4000_0000, 32'h4050_0000});
    vecs.push_back('{1'b1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000});
    vecs.push_back('{1'b0, 32'hC000_0000, 32'h4040_0000, 32'h0000_0000});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000});
    vecs.push_back('{1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000});
    vecs.push_back('{1'b1, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000});
    vecs.push_back('{1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h7F80_0000});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'h3F80_0000, 32'h0000_0000});
    vecs.push_back('{1'b0, 32'h0040_0000, 32'h3F80_0000, 32'h0000_0000});
    vecs.push_back('{1'b0, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000});
    vecs.push_back('{1'b0, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000});
    // Six-term dot product, w = 0.5
    vecs.push_back('{1'b1, 32'h3F80_0000, 32'h3F00_0000, 32'h3F00_0000});
    vecs.push_back('{1'b0, 32'h4000_0000, 32'h3F00_0000, 32'h3FC0_0000});
    vecs.push_back('{1'b0, 32'h4040_0000, 32'h3F00_0000, 32'h4040_0000});
    vecs.push_back('{1'b0, 32'h4080_0000, 32'h3F00_0000, 32'h40A0_0000});
    vecs.push_back('{1'b0, 32'h40A0_0000, 32'h3F00_0000, 32'h40F0_0000});
    vecs.push_back('{1'b0, 32'h40C0_0000, 32'h3F00_0000, 32'h4128_0000});

    prev = 32'd0;
    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        do_reset();
        prev = 32'd0;
      end
      run_window(vecs[i].xv, vecs[i].wv, ym, ye);
      check($sformatf("vec%0d_hold", i), ym, prev);
      check($sformatf("vec%0d_y", i), ye, vecs[i].exp_y);
      prev = vecs[i].exp_y;
    end

    // Reset during phase 1 aborts the in-flight 2.0*3.0.
    do_reset();
    @(negedge clk);
    reset = 1'b0;
    x = 32'h4000_0000;
    w = 32'h4040_0000;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check("abort_reset_y", y, 32'd0);
    run_window(32'h3F80_0000, 32'h3F80_0000, ym, ye);
    check("abort_hold", ym, 32'd0);
    check("abort_after_y", ye, 32'h3F80_0000);

    // Randomized windows against the model.
    do_reset();
    acc = 32'd0;
    for (int k = 0; k < 150; k++) begin
      xr = rand_operand();
      wr = rand_operand();
      run_window(xr, wr, ym, ye);
      check($sformatf("rnd%0d_hold", k), ym, acc);
      acc = model_add(acc, model_mul(xr, wr));
      check($sformatf("rnd%0d_y x=%08h w=%08h", k, xr, wr), ye, acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
